hilo_div_seq: RTL and testbench

Sequencer and HI/LO register bank sitting directly downstream of the iterative divider and beside the multiplier in the multicycle datapath. On a divide request from the control unit it:
- drives the divider's enable for a fixed cycle budget;
- detects divide-by-zero;
- captures the divider's remainder/quotient into HI/LO.

It also accepts multiplier results and mthi/mtlo writes, and is the single owner of the architectural HI and LO registers.

---
 rtl/hilo_div_seq.sv | 143 ++++++++++++++
 tb/tb_hilo_div_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_seq.sv
// hilo_div_seq: divide sequencer and owner of the architectural HI/LO registers.
//
// On a divide request the block holds the divider enable high for a fixed
// DIV_CYCLES window. It aborts after two cycles if the divider flags a zero
// divisor. Otherwise it copies remainder/quotient into HI/LO at the end of the
// window. Multiplier results and mthi/mtlo writes are accepted only while no
// divide is in flight (IDLE and DONE).
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   div_start              divide request, sampled only in IDLE
//   div_hi_in, div_lo_in   divider remainder / quotient
//   div_zero_in            divider divide-by-zero flag
//   div_control            divider enable, high only in RUN
//   mult_done              multiplier result valid pulse
//   mult_hi, mult_lo       multiplier product halves
//   hi_write, lo_write     mthi / mtlo strobes
//   wdata                  mthi / mtlo data
//   hi, lo                 architectural HI / LO
//   busy                   high in RUN
//   done                   one-cycle pulse after a divide result is written
//   div_zero_exc           one-cycle pulse after a divide-by-zero abort
module hilo_div_seq #(
  parameter int unsigned DIV_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        div_start,
  input  logic [31:0] div_hi_in,
  input  logic [31:0] div_lo_in,
  input  logic        div_zero_in,
  output logic        div_control,
  input  logic        mult_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        hi_write,
  input  logic        lo_write,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc
);

  // Counter only needs to reach DIV_CYCLES-1.
  localparam int unsigned CntW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StExc} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              host_wr_en;
  logic              div_capture;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_control  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    div_zero_exc = 1'b0;
    host_wr_en   = 1'b0;
    div_capture  = 1'b0;

    unique case (state_q)
      StIdle: begin
        host_wr_en = 1'b1;
        if (div_start) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        div_control = 1'b1;
        busy        = 1'b1;
        cnt_d       = cnt_q + CntW'(1);
        // The zero flag is only trusted once the divider has seen two enabled edges.
        if (cnt_q == CntOne && div_zero_in) begin
          state_d = StExc;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          div_capture = 1'b1;
          state_d     = StDone;
          cnt_d       = '0;
        end
      end
      StDone: begin
        done       = 1'b1;
        host_wr_en = 1'b1;
        state_d    = StIdle;
      end
      StExc: begin
        div_zero_exc = 1'b1;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // HI/LO next state, lowest priority first so later assignments win.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (host_wr_en) begin
      if (hi_write) hi_d = wdata;
      if (lo_write) lo_d = wdata;
      if (mult_done) begin
        hi_d = mult_hi;
        lo_d = mult_lo;
      end
    end
    if (div_capture) begin
      hi_d = div_hi_in;
      lo_d = div_lo_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_hilo_div_seq.sv
// Directed bench for hilo_div_seq with a behavioural signed divider that only
// presents valid results after |q|+2 enabled cycles.
module tb_hilo_div_seq;

  localparam int unsigned DC = 64;

  logic        clock;
  logic        reset;
  logic        div_start;
  logic [31:0] div_hi_in;
  logic [31:0] div_lo_in;
  logic        div_zero_in;
  logic        div_control;
  logic        mult_done;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero_exc;

  int checks;
  int errors;

  hilo_div_seq #(.DIV_CYCLES(DC)) dut (
    .clock       (clock),
    .reset       (reset),
    .div_start   (div_start),
    .div_hi_in   (div_hi_in),
    .div_lo_in   (div_lo_in),
    .div_zero_in (div_zero_in),
    .div_control (div_control),
    .mult_done   (mult_done),
    .mult_hi     (mult_hi),
    .mult_lo     (mult_lo),
    .hi_write    (hi_write),
    .lo_write    (lo_write),
    .wdata       (wdata),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_zero_exc(div_zero_exc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Divider model: operands set by the bench, result valid after |q|+2 enabled cycles.
  logic signed [31:0] dvd;
  logic signed [31:0] dvs;
  int unsigned        mcnt;

  always @(posedge clock) mcnt <= div_control ? mcnt + 1 : 0;

  function automatic int unsigned mag(input logic signed [31:0] v);
    return (v < 0) ? 32'(-v) : 32'(v);
  endfunction

  always_comb begin
    logic signed [31:0] q;
    div_zero_in = 1'b0;
    div_hi_in   = 32'hDEAD_BEEF;
    div_lo_in   = 32'hDEAD_BEEF;
    q           = 0;
    if (div_control) begin
      if (dvs == 0) begin
        div_zero_in = 1'b1;
      end else begin
        q = dvd / dvs;
        if (mcnt >= mag(q) + 2) begin
          div_hi_in = dvd % dvs;
          div_lo_in = q;
        end
      end
    end
  end

  // Starts a divide and waits (bounded) for done or div_zero_exc. Returns at
  // the negedge of the pulse cycle. lat counts cycles from the start edge.
  task automatic do_div(input logic signed [31:0] a, input logic signed [31:0] b,
                        output int ctl, output int lat, output logic got_done,
                        output logic got_exc, output logic timed_out);
    dvd = a;
    dvs = b;
    div_start = 1'b1;
    @(posedge clock);
    #1 div_start = 1'b0;
    ctl = 0;
    lat = 0;
    got_done = 1'b0;
    got_exc = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 4 * DC; i++) begin
      @(negedge clock);
      lat++;
      if (div_control) ctl++;
      if (done || div_zero_exc) begin
        got_done = done;
        got_exc = div_zero_exc;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    div_start = 1'b1;
    #12;
    checks++;
    if ({div_control, busy, done, div_zero_exc} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000", {div_control, busy, done, div_zero_exc});
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", hi, lo);
    end
    div_start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_divide(input logic signed [31:0] a, input logic signed [31:0] b,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int ctl, lat;
    logic gd, ge, to;
    do_div(a, b, ctl, lat, gd, ge, to);
    checks++;
    if (to || !gd || ge) begin
      errors++;
      $display("FAIL div_end %0d/%0d: timeout=%b done=%b exc=%b want 0/1/0", a, b, to, gd, ge);
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL div_result %0d/%0d: got hi=%h lo=%h want hi=%h lo=%h",
               a, b, hi, lo, exp_hi, exp_lo);
    end
    checks++;
    if (ctl != DC || lat != DC + 1) begin
      errors++;
      $display("FAIL div_timing %0d/%0d: ctl=%0d lat=%0d want %0d/%0d", a, b, ctl, lat, DC, DC + 1);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || div_control !== 1'b0) begin
      errors++;
      $display("FAIL div_done_width: done=%b busy=%b ctl=%b want 000", done, busy, div_control);
    end
  endtask

  task automatic test_div_zero;
    int ctl, lat;
    logic gd, ge, to;
    hi_write = 1'b1;
    wdata = 32'hAAAA_0000;
    @(posedge clock);
    #1 hi_write = 1'b0;
    lo_write = 1'b1;
    wdata = 32'h0000_5555;
    @(posedge clock);
    #1 lo_write = 1'b0;
    checks++;
    if (hi !== 32'hAAAA_0000 || lo !== 32'h0000_5555) begin
      errors++;
      $display("FAIL mthi_mtlo: got hi=%h lo=%h want aaaa0000/00005555", hi, lo);
    end
    do_div(32'sd5, 32'sd0, ctl, lat, gd, ge, to);
    checks++;
    if (to || gd || !ge || lat != 3 || ctl != 2) begin
      errors++;
      $display("FAIL dz_exc: to=%b done=%b exc=%b lat=%0d ctl=%0d want 0/0/1/3/2",
               to, gd, ge, lat, ctl);
    end
    checks++;
    if (hi !== 32'hAAAA_0000 || lo !== 32'h0000_5555 || div_control !== 1'b0) begin
      errors++;
      $display("FAIL dz_hold: hi=%h lo=%h ctl=%b want aaaa0000/00005555/0", hi, lo, div_control);
    end
    @(negedge clock);
    checks++;
    if (div_zero_exc !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL dz_width: exc=%b done=%b want 0/0", div_zero_exc, done);
    end
  endtask

  task automatic test_mult_write;
    int ctl, lat;
    logic gd, ge, to;
    hi_write = 1'b1;
    wdata = 32'h12;
    mult_done = 1'b1;
    mult_hi = 32'h34;
    mult_lo = 32'h56;
    @(posedge clock);
    #1 hi_write = 1'b0;
    mult_done = 1'b0;
    checks++;
    if (hi !== 32'h34 || lo !== 32'h56) begin
      errors++;
      $display("FAIL mult_prio: got hi=%h lo=%h want 34/56", hi, lo);
    end
    fork
      do_div(32'sd7, 32'sd2, ctl, lat, gd, ge, to);
      begin
        repeat (10) @(posedge clock);
        #1 mult_done = 1'b1;
        mult_hi = 32'h77;
        mult_lo = 32'h88;
        lo_write = 1'b1;
        wdata = 32'h99;
        @(posedge clock);
        #1 mult_done = 1'b0;
        lo_write = 1'b0;
        checks++;
        if (hi !== 32'h34 || lo !== 32'h56) begin
          errors++;
          $display("FAIL mult_in_run: got hi=%h lo=%h want 34/56", hi, lo);
        end
      end
    join
    checks++;
    if (to || !gd || hi !== 32'h1 || lo !== 32'h3) begin
      errors++;
      $display("FAIL mult_run_result: to=%b done=%b hi=%h lo=%h want 0/1/1/3", to, gd, hi, lo);
    end
    @(negedge clock);
  endtask

  task automatic test_async_reset;
    int ctl, lat;
    logic gd, ge, to;
    dvd = 32'sd100;
    dvs = 32'sd7;
    div_start = 1'b1;
    @(posedge clock);
    #1 div_start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || div_control !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: hi=%h lo=%h ctl=%b busy=%b want 0/0/0/0",
               hi, lo, div_control, busy);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || div_control !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_idle: busy=%b ctl=%b want 0/0", busy, div_control);
    end
    do_div(32'sd9, 32'sd3, ctl, lat, gd, ge, to);
    checks++;
    if (to || !gd || hi !== 32'h0 || lo !== 32'h3 || lat != DC + 1) begin
      errors++;
      $display("FAIL post_reset_div: to=%b done=%b hi=%h lo=%h lat=%0d want 0/1/0/3/%0d",
               to, gd, hi, lo, lat, DC + 1);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    logic signed [31:0] av [3];
    logic signed [31:0] bv [3];
    logic [31:0]        eh [3];
    logic [31:0]        el [3];
    int k, low, high;
    av = '{32'sd20, -32'sd9, 32'sd13};
    bv = '{32'sd6, 32'sd4, -32'sd5};
    eh = '{32'h2, 32'hFFFF_FFFF, 32'h3};
    el = '{32'h3, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    k = 0;
    low = 0;
    high = 0;
    dvd = av[0];
    dvs = bv[0];
    div_start = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 8 * DC && k < 3; i++) begin
      @(negedge clock);
      if (div_control) begin
        if (low > 0) begin
          checks++;
          if (low != 2) begin
            errors++;
            $display("FAIL b2b_gap%0d: low cycles=%0d want 2", k, low);
          end
        end
        low = 0;
        high++;
      end else begin
        low++;
      end
      if (done) begin
        checks++;
        if (hi !== eh[k] || lo !== el[k] || high != DC || div_zero_exc !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result%0d: hi=%h lo=%h ctl=%0d exc=%b want %h/%h/%0d/0",
                   k, hi, lo, high, div_zero_exc, eh[k], el[k], DC);
        end
        high = 0;
        k++;
        if (k < 3) begin
          dvd = av[k];
          dvs = bv[k];
        end else begin
          div_start = 1'b0;
        end
      end
    end
    checks++;
    if (k != 3) begin
      errors++;
      $display("FAIL b2b_count: completed=%0d want 3", k);
    end
    div_start = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: busy=%b want 0", busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    div_start = 1'b0;
    mult_done = 1'b0;
    mult_hi = '0;
    mult_lo = '0;
    hi_write = 1'b0;
    lo_write = 1'b0;
    wdata = '0;
    dvd = 0;
    dvs = 1;
    test_reset();
    test_divide(32'sd7, 32'sd2, 32'h1, 32'h3);
    test_divide(-32'sd7, 32'sd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_divide(32'sd7, -32'sd2, 32'h1, 32'hFFFF_FFFD);
    test_div_zero();
    test_mult_write();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
